// File: rtl/data_bus_responder.sv
`default_nettype none
// ============================================================================
// data_bus_responder : cpu data-port responder (word RAM + GPIO/CYCLE/UART MMIO)
// Revision 1.0 - initial release
// ============================================================================
module data_bus_responder #(
  parameter int          RAM_WORDS    = 1024,
  parameter logic [31:0] MMIO_BASE    = 32'h1000_0000,
  parameter int          GPIO_W       = 8,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wr_data_i,
  input  logic              mem_wr_sig_i,
  output logic [31:0]       mem_rd_data_o,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              uart_tx_o
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  localparam logic [1:0] OFF_GPIO   = 2'd0;
  localparam logic [1:0] OFF_CYCLE  = 2'd1;
  localparam logic [1:0] OFF_TXDATA = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---------------------------------------------------------------- decode
  logic       ram_hit;
  logic       mmio_hit;
  logic [1:0] off;
  logic       wr_ram;
  logic       wr_gpio;
  logic       wr_cycle;
  logic       wr_txdata;
  logic       wr_status;
  logic       unused_addr;

  assign ram_hit     = (mem_addr_i < RAM_BYTES);
  assign mmio_hit    = (mem_addr_i[31:4] == MMIO_BASE[31:4]);
  assign off         = mem_addr_i[3:2];
  assign unused_addr = ^mem_addr_i[1:0];

  assign wr_ram    = mem_wr_sig_i && ram_hit;
  assign wr_gpio   = mem_wr_sig_i && !ram_hit && mmio_hit && (off == OFF_GPIO);
  assign wr_cycle  = mem_wr_sig_i && !ram_hit && mmio_hit && (off == OFF_CYCLE);
  assign wr_txdata = mem_wr_sig_i && !ram_hit && mmio_hit && (off == OFF_TXDATA);
  assign wr_status = mem_wr_sig_i && !ram_hit && mmio_hit && (off == OFF_STATUS);

  // ---------------------------------------------------------------- storage
  logic [31:0] ram_q  [RAM_WORDS];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  // RAM and FIFO payload are deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram_q[mem_addr_i[AW+1:2]] <= mem_wr_data_i;
    end
  end

  // ---------------------------------------------------------------- registers
  logic [GPIO_W-1:0] gpio_q,  gpio_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [PW-1:0]     wptr_q,  wptr_d;
  logic [PW-1:0]     rptr_q,  rptr_d;
  logic [PW:0]       cnt_q,   cnt_d;
  logic              ovf_q,   ovf_d;
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     bcnt_q,  bcnt_d;
  logic [2:0]        idx_q,   idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q,    tx_d;

  logic fifo_full;
  logic fifo_empty;
  logic tx_busy;
  logic bit_end;
  logic pop;
  logic push_ok;
  logic ovf_set;

  assign fifo_full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign tx_busy    = (state_q != S_IDLE);
  assign bit_end    = (bcnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wptr_q] <= mem_wr_data_i[7:0];
    end
  end

  // A push into a full FIFO still lands if the transmitter frees a slot this cycle.
  assign push_ok = wr_txdata && (!fifo_full || pop);
  assign ovf_set = wr_txdata && fifo_full && !pop;

  always_comb begin
    gpio_d  = wr_gpio  ? mem_wr_data_i[GPIO_W-1:0] : gpio_q;
    cycle_d = wr_cycle ? mem_wr_data_i : cycle_q + 32'd1;
    ovf_d   = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (wr_status && mem_wr_data_i[2]) begin
      ovf_d = 1'b0;
    end
    wptr_d = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop     ? rptr_q + 1'b1 : rptr_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // ---------------------------------------------------------------- TX FSM
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
          bcnt_d  = '0;
          shift_d = fifo_q[rptr_q];
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bcnt_d  = '0;
          idx_d   = 3'd0;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bcnt_d  = '0;
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bcnt_d = '0;
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_START;
            shift_d = fifo_q[rptr_q];
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpio_q  <= '0;
      cycle_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      gpio_q  <= gpio_d;
      cycle_q <= cycle_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // ---------------------------------------------------------------- read path
  always_comb begin
    mem_rd_data_o = 32'd0;
    if (ram_hit) begin
      mem_rd_data_o = ram_q[mem_addr_i[AW+1:2]];
    end else if (mmio_hit) begin
      case (off)
        OFF_GPIO:   mem_rd_data_o = 32'(gpio_q);
        OFF_CYCLE:  mem_rd_data_o = cycle_q;
        OFF_TXDATA: mem_rd_data_o = 32'd0;
        OFF_STATUS: mem_rd_data_o = {28'd0, fifo_empty, ovf_q, fifo_full, tx_busy};
        default:    mem_rd_data_o = 32'd0;
      endcase
    end
  end

  assign gpio_o    = gpio_q;
  assign uart_tx_o = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`default_nettype none
// ============================================================================
// tb_data_bus_responder : directed self-checking bench for data_bus_responder
// Revision 1.0 - initial release
// ============================================================================
module tb_data_bus_responder;

  localparam logic [31:0] MMIO  = 32'h1000_0000;
  localparam logic [31:0] A_GP  = MMIO + 32'h0;
  localparam logic [31:0] A_CYC = MMIO + 32'h4;
  localparam logic [31:0] A_TX  = MMIO + 32'h8;
  localparam logic [31:0] A_ST  = MMIO + 32'hC;

  logic        clk;
  logic        reset_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_sig;
  logic [31:0] mem_rd_data;
  logic [7:0]  gpio;
  logic        uart_tx;

  int n_total;
  int n_pass;
  bit rec [512];
  int k;
  bit recording;

  data_bus_responder #(
    .RAM_WORDS   (1024),
    .MMIO_BASE   (MMIO),
    .GPIO_W      (8),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_addr_i   (mem_addr),
    .mem_wr_data_i(mem_wr_data),
    .mem_wr_sig_i (mem_wr_sig),
    .mem_rd_data_o(mem_rd_data),
    .gpio_o       (gpio),
    .uart_tx_o    (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one bus cycle at the falling edge; the sample point sits 1ns later.
  task automatic step(input logic [31:0] addr, input logic [31:0] wdata, input logic wr);
    @(negedge clk);
    mem_addr    = addr;
    mem_wr_data = wdata;
    mem_wr_sig  = wr;
    #1;
    if (recording) begin
      rec[k] = uart_tx;
      k++;
    end
  endtask

  function automatic logic [39:0] frame_of(input logic [7:0] b);
    logic [39:0] f;
    for (int i = 0; i < 40; i++) begin
      f[i] = (i < 4) ? 1'b0 : (i < 36) ? b[(i - 4) / 4] : 1'b1;
    end
    return f;
  endfunction

  function automatic logic [39:0] rec_frame(input int base);
    logic [39:0] f;
    for (int i = 0; i < 40; i++) begin
      f[i] = rec[base + i];
    end
    return f;
  endfunction

  initial begin
    int bad;
    n_total     = 0;
    n_pass      = 0;
    k           = 0;
    recording   = 1'b0;
    reset_n     = 1'b0;
    mem_addr    = A_ST;
    mem_wr_data = 32'd0;
    mem_wr_sig  = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_status", mem_rd_data, 32'h8);
    check_eq("rst_tx", uart_tx, 1'b1);
    check_eq("rst_gpio", gpio, 8'h00);
    mem_addr = A_CYC;
    #1;
    check_eq("rst_cycle", mem_rd_data, 32'd0);
    reset_n = 1'b1;

    // CYCLE counts from reset release
    step(A_CYC, 32'd0, 1'b0);
    check_eq("cycle_1", mem_rd_data, 32'd1);
    step(A_CYC, 32'd0, 1'b0);
    check_eq("cycle_2", mem_rd_data, 32'd2);

    // RAM write/read timing and byte-offset aliasing
    step(32'h10, 32'h1111_1111, 1'b1);
    step(32'h10, 32'hDEAD_BEEF, 1'b1);
    check_eq("ram_old", mem_rd_data, 32'h1111_1111);
    step(32'h10, 32'd0, 1'b0);
    check_eq("ram_new", mem_rd_data, 32'hDEAD_BEEF);
    step(32'h12, 32'd0, 1'b0);
    check_eq("ram_alias", mem_rd_data, 32'hDEAD_BEEF);
    step(32'h2000_0000, 32'd0, 1'b0);
    check_eq("unmapped", mem_rd_data, 32'd0);

    // GPIO
    step(A_GP, 32'h0000_01A5, 1'b1);
    step(A_GP, 32'd0, 1'b0);
    check_eq("gpio_pin", gpio, 8'hA5);
    check_eq("gpio_rd", mem_rd_data, 32'h0000_00A5);

    // CYCLE load and wrap
    step(A_CYC, 32'hFFFF_FFFE, 1'b1);
    step(A_CYC, 32'd0, 1'b0);
    check_eq("cyc_load", mem_rd_data, 32'hFFFF_FFFE);
    step(A_CYC, 32'd0, 1'b0);
    check_eq("cyc_max", mem_rd_data, 32'hFFFF_FFFF);
    step(A_CYC, 32'd0, 1'b0);
    check_eq("cyc_wrap", mem_rd_data, 32'd0);

    // Single UART frame 0x55
    k = 0;
    recording = 1'b1;
    step(A_TX, 32'h55, 1'b1);
    for (int i = 0; i < 42; i++) begin
      step(A_ST, 32'd0, 1'b0);
      if (i == 0)  check_eq("tx_pending_st", mem_rd_data, 32'h0);
      if (i == 19) check_eq("tx_busy_st", mem_rd_data, 32'h9);
    end
    recording = 1'b0;
    check_eq("tx_pre_idle", {rec[0], rec[1]}, 2'b11);
    check_eq("tx_frame_55", rec_frame(2), frame_of(8'h55));
    check_eq("tx_post_idle", rec[42], 1'b1);
    check_eq("tx_done_st", mem_rd_data, 32'h8);

    // FIFO back-to-back, overflow and W1C clear
    k = 0;
    recording = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step(A_TX, 32'(j), 1'b1);
    end
    step(A_ST, 32'd0, 1'b0);
    check_eq("ovf_st", mem_rd_data, 32'h7);
    step(A_ST, 32'h4, 1'b1);
    step(A_ST, 32'd0, 1'b0);
    check_eq("ovf_clr_st", mem_rd_data, 32'h3);
    for (int i = 0; i < 195; i++) begin
      step(A_ST, 32'd0, 1'b0);
    end
    recording = 1'b0;
    for (int f = 0; f < 5; f++) begin
      check_eq($sformatf("fifo_frame_%0d", f), rec_frame(2 + 40 * f), frame_of(8'(f)));
    end
    check_eq("fifo_idle_after", rec[202], 1'b1);
    check_eq("fifo_done_st", mem_rd_data, 32'h8);

    // Reset in the middle of a frame
    step(A_GP, 32'h3C, 1'b1);
    step(A_TX, 32'h00, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(A_ST, 32'd0, 1'b0);
    end
    check_eq("mid_tx_low", uart_tx, 1'b0);
    check_eq("mid_gpio", gpio, 8'h3C);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("arst_tx", uart_tx, 1'b1);
    check_eq("arst_gpio", gpio, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step(A_ST, 32'd0, 1'b0);
      if (uart_tx !== 1'b1) bad++;
    end
    check_eq("post_rst_tx_idle", bad, 0);
    check_eq("post_rst_st", mem_rd_data, 32'h8);
    check_eq("post_rst_gpio", gpio, 8'h00);
    step(32'h10, 32'd0, 1'b0);
    check_eq("ram_kept", mem_rd_data, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
